// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
// Build option: IMEM_LOADER_CHECKSUM_EN adds the CHECK state (3-bit state).
package imem_loader_pkg;

  localparam logic [31:0] HALT_INSTR = 32'hFC00_0000;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    CHECK = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;
`endif

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Assembles MSB-first bytes into 32-bit words; word_complete pulses with the
// 4th byte and word_next carries the finished word in that same cycle.
module imem_loader_byte_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_complete
);

  // Only the three newest bytes need storing: the fourth is taken straight
  // from byte_in when the word completes, so the top byte is never read back.
  logic [23:0] word_q;
  logic [1:0]  byte_cnt;

  assign word_next     = {word_q, byte_in};
  assign word_complete = shift_en && (byte_cnt == 2'd3);

  // Shift register and wrapping byte counter
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      word_q   <= '0;
      byte_cnt <= '0;
    end else if (shift_en) begin
      word_q   <= word_next[23:0];
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream into instruction memory word by word from address 0,
// stopping after the HALT word or on overflow of MEM_WORDS.
// Build option: IMEM_LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 256,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_start,
  input  logic [7:0]                  i_rx_data,
  input  logic                        i_rx_valid,
  output logic                        o_rx_ready,
  output logic                        o_mem_we,
  output logic [ADDR_WIDTH-1:0]       o_mem_addr,
  output logic [31:0]                 o_mem_wdata,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_error,
  output logic [$clog2(MEM_WORDS):0]  o_word_count
);

  localparam int unsigned WC_W = $clog2(MEM_WORDS) + 1;
  localparam logic [WC_W-1:0] MAX_WC = WC_W'(MEM_WORDS);

  state_t      state, next_state;
  logic        start_load;
  logic        byte_accept;
  logic        shift_en;
  logic        word_complete;
  logic        overflow;
  logic [31:0] word_next;

  imem_loader_byte_assembler u_asm (
    .clk           (clk),
    .reset         (reset),
    .clear         (start_load),
    .shift_en      (shift_en),
    .byte_in       (i_rx_data),
    .word_next     (word_next),
    .word_complete (word_complete)
  );

  assign start_load  = i_start && ((state == IDLE) || (state == DONE));
  assign byte_accept = i_rx_valid && o_rx_ready;
  assign shift_en    = byte_accept && (state == LOAD);
  assign overflow    = word_complete && (o_word_count == MAX_WC);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state decode
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: if (start_load) next_state = LOAD;
      LOAD: begin
        if (word_complete) next_state = overflow ? DONE : WRITE;
      end
      WRITE: begin
        if (o_mem_wdata == HALT_INSTR) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          next_state = CHECK;
`else
          next_state = DONE;
`endif
        end else begin
          next_state = LOAD;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: if (byte_accept) next_state = DONE;
`endif
      default: next_state = IDLE;
    endcase
  end

  // Byte handshake decodes directly from the current state
  always_comb begin
    o_rx_ready = (state == LOAD);
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (state == CHECK) o_rx_ready = 1'b1;
`endif
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] xor_sum;

  // Running XOR of every data byte of the current load
  always_ff @(posedge clk) begin
    if (!reset || start_load) xor_sum <= '0;
    else if (shift_en)        xor_sum <= xor_sum ^ i_rx_data;
  end
`endif

  // Registered outputs: status flags follow next_state so they line up with
  // the state they describe; memory address/data are captured on word completion.
  always_ff @(posedge clk) begin
    if (!reset) begin
      o_mem_we     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
      o_word_count <= '0;
    end else begin
      o_mem_we <= (next_state == WRITE);
      o_done   <= (next_state == DONE);
`ifdef IMEM_LOADER_CHECKSUM_EN
      o_busy   <= (next_state == LOAD) || (next_state == WRITE) || (next_state == CHECK);
`else
      o_busy   <= (next_state == LOAD) || (next_state == WRITE);
`endif
      if (start_load) begin
        o_word_count <= '0;
        o_mem_addr   <= '0;
        o_error      <= 1'b0;
      end
      if ((state == LOAD) && word_complete) begin
        if (overflow) begin
          o_error <= 1'b1;
        end else begin
          o_mem_addr  <= ADDR_WIDTH'(o_word_count) << 2;
          o_mem_wdata <= word_next;
        end
      end
      if (state == WRITE) o_word_count <= o_word_count + WC_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
      if ((state == CHECK) && byte_accept && (i_rx_data != xor_sum)) o_error <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes and end-of-load status are
// queued by the stimulus; a monitor pops and compares as the DUT produces them.
module tb_imem_loader;

  localparam int unsigned MEM_WORDS = 4;
  localparam int unsigned AW        = 32;
  localparam int unsigned WCW       = $clog2(MEM_WORDS) + 1;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           i_start = 1'b0;
  logic [7:0]     i_rx_data = 8'h00;
  logic           i_rx_valid = 1'b0;
  logic           o_rx_ready;
  logic           o_mem_we;
  logic [AW-1:0]  o_mem_addr;
  logic [31:0]    o_mem_wdata;
  logic           o_busy;
  logic           o_done;
  logic           o_error;
  logic [WCW-1:0] o_word_count;

  always #5 clk = ~clk;

  imem_loader #(.MEM_WORDS(MEM_WORDS), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_start      (i_start),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .o_rx_ready   (o_rx_ready),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_error      (o_error),
    .o_word_count (o_word_count)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    logic           err;
    logic [WCW-1:0] cnt;
  } st_t;

  wr_t wq[$];
  st_t sq[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    wq.push_back(e);
  endtask

  task automatic push_st(input logic e, input logic [WCW-1:0] c);
    st_t s;
    s.err = e;
    s.cnt = c;
    sq.push_back(s);
  endtask

  // Monitor: compares every write strobe and every rising o_done
  initial begin
    logic prev_we;
    logic prev_done;
    wr_t  w;
    st_t  s;
    prev_we   = 1'b0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (o_mem_we) begin
        check("we_single_cycle", {63'd0, prev_we}, 64'd0);
        check("rx_ready_in_write", {63'd0, o_rx_ready}, 64'd0);
        if (wq.size() == 0) begin
          timeout_fail("unexpected_write");
        end else begin
          w = wq.pop_front();
          check("wr_addr", {32'd0, o_mem_addr}, {32'd0, w.addr});
          check("wr_data", {32'd0, o_mem_wdata}, {32'd0, w.data});
        end
      end
      if (o_done && !prev_done) begin
        if (sq.size() == 0) begin
          timeout_fail("unexpected_done");
        end else begin
          s = sq.pop_front();
          check("done_error", {63'd0, o_error}, {63'd0, s.err});
          check("done_count", {{(64-WCW){1'b0}}, o_word_count}, {{(64-WCW){1'b0}}, s.cnt});
          check("done_busy", {63'd0, o_busy}, 64'd0);
        end
      end
      prev_we   = o_mem_we;
      prev_done = o_done;
    end
  end

  task automatic do_reset();
    reset      = 1'b0;
    i_start    = 1'b0;
    i_rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_we",    {63'd0, o_mem_we}, 64'd0);
    check("rst_addr",  {32'd0, o_mem_addr}, 64'd0);
    check("rst_wdata", {32'd0, o_mem_wdata}, 64'd0);
    check("rst_busy",  {63'd0, o_busy}, 64'd0);
    check("rst_done",  {63'd0, o_done}, 64'd0);
    check("rst_error", {63'd0, o_error}, 64'd0);
    check("rst_count", {{(64-WCW){1'b0}}, o_word_count}, 64'd0);
    check("rst_ready", {63'd0, o_rx_ready}, 64'd0);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("start_busy",  {63'd0, o_busy}, 64'd1);
    check("start_error", {63'd0, o_error}, 64'd0);
    check("start_ready", {63'd0, o_rx_ready}, 64'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic rdy;
    logic ok;
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      rdy = o_rx_ready;
      @(negedge clk);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("byte_accept");
    if (gap > 0) begin
      i_rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], gap);
  endtask

  task automatic wait_done();
    logic ok;
    i_rx_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (o_done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) timeout_fail("wait_done");
    @(negedge clk);
  endtask

  initial begin
    do_reset();

    // Basic two-word program, valid held high
    push_wr(32'h0, 32'h0000_0020);
    push_wr(32'h4, 32'hFC00_0000);
    push_st(1'b0, WCW'(2));
    pulse_start();
    send_word(32'h0000_0020, 0);
    send_word(32'hFC00_0000, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'hDC, 0);
`endif
    wait_done();

    // Restart from DONE with valid toggling every other cycle
    push_wr(32'h0, 32'h1234_5678);
    push_wr(32'h4, 32'hFC00_0000);
    push_st(1'b0, WCW'(2));
    pulse_start();
    send_word(32'h1234_5678, 1);
    send_word(32'hFC00_0000, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'hF4, 1);
`endif
    wait_done();

    // Overflow: 4-word memory, five non-HALT words
    push_wr(32'h0, 32'h0000_0001);
    push_wr(32'h4, 32'h0000_0002);
    push_wr(32'h8, 32'h0000_0003);
    push_wr(32'hC, 32'h0000_0004);
    push_st(1'b1, WCW'(4));
    pulse_start();
    send_word(32'h0000_0001, 0);
    send_word(32'h0000_0002, 0);
    send_word(32'h0000_0003, 0);
    send_word(32'h0000_0004, 0);
    send_word(32'h0000_0005, 0);
    wait_done();
    check("ovf_no_ready", {63'd0, o_rx_ready}, 64'd0);

    // Restart after error clears it; i_start inside LOAD is ignored
    push_wr(32'h0, 32'hAABB_CCDD);
    push_wr(32'h4, 32'hFC00_0000);
    push_st(1'b0, WCW'(2));
    pulse_start();
    send_word(32'hAABB_CCDD, 0);
    send_byte(8'hFC, 0);
    i_rx_valid = 1'b0;
    i_start    = 1'b1;
    @(negedge clk);
    i_start    = 1'b0;
    check("start_in_load_busy", {63'd0, o_busy}, 64'd1);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'hFC, 0);
`endif
    wait_done();

    // Reset two bytes into the second word abandons the load
    push_wr(32'h0, 32'h1111_1111);
    pulse_start();
    send_word(32'h1111_1111, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    do_reset();
    repeat (10) @(negedge clk);
    push_wr(32'h0, 32'h2222_2222);
    push_wr(32'h4, 32'hFC00_0000);
    push_st(1'b0, WCW'(2));
    pulse_start();
    send_word(32'h2222_2222, 0);
    send_word(32'hFC00_0000, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'hFC, 0);
`endif
    wait_done();

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong checksum byte flags an error
    push_wr(32'h0, 32'h1234_5678);
    push_wr(32'h4, 32'hFC00_0000);
    push_st(1'b1, WCW'(2));
    pulse_start();
    send_word(32'h1234_5678, 0);
    send_word(32'hFC00_0000, 0);
    send_byte(8'h00, 0);
    wait_done();
`endif

    repeat (5) @(negedge clk);
    check("wq_drained", 64'(wq.size()), 64'd0);
    check("sq_drained", 64'(sq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
